// File: rtl/history_predictor_if.sv
// history_predictor_if
//   Groups the prediction-request, branch-resolution and prediction-response
//   signals of the global-history branch predictor.
//   Parameter HIST_BITS : width of the PC index fields.
//   master modport : fetch side. It drives request/req_pc/result/res_pc/taken
//                    and reads prediction/pred_valid/pred_strong.
//   slave modport  : predictor side. It has the opposite directions.
interface history_predictor_if #(
  parameter int HIST_BITS = 4
);
  logic                 request;
  logic [HIST_BITS-1:0] req_pc;
  logic                 result;
  logic [HIST_BITS-1:0] res_pc;
  logic                 taken;
  logic                 prediction;
  logic                 pred_valid;
  logic                 pred_strong;

  modport master (
    output request, req_pc, result, res_pc, taken,
    input  prediction, pred_valid, pred_strong
  );

  modport slave (
    input  request, req_pc, result, res_pc, taken,
    output prediction, pred_valid, pred_strong
  );
endinterface

// File: rtl/history_predictor.sv
// history_predictor
//   This is a global-history branch direction predictor. A table of 2^HIST_BITS
//   saturating counters is indexed by the global taken/not-taken history.
//   When USE_PC is set, the history is XORed with the low PC bits (gshare).
//   The predictor answers one request and absorbs one resolved branch per
//   cycle. Both use the history as it was held before the clock edge.
// Ports
//   clk : rising-edge clock.
//   rst : asynchronous, active-high reset. It sets every counter to maximum
//         (strongly taken), clears the history and clears all outputs.
//   bus : history_predictor_if.slave. It carries the request/result inputs and
//         the registered prediction/pred_valid/pred_strong outputs.
module history_predictor #(
  parameter int HIST_BITS = 4,
  parameter int CTR_BITS  = 2,
  parameter bit USE_PC    = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  history_predictor_if.slave     bus
);
  localparam int                  DEPTH   = 1 << HIST_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_ONE = CTR_BITS'(1);

  logic [HIST_BITS-1:0]      hist_q, hist_d;
  logic [DEPTH*CTR_BITS-1:0] ctr_flat;
  logic [HIST_BITS-1:0]      req_idx, res_idx;
  logic [CTR_BITS-1:0]       req_ctr;

  logic prediction_q, prediction_d;
  logic pred_valid_q, pred_valid_d;
  logic pred_strong_q, pred_strong_d;

  // Both indices use the pre-edge history. A request and a result on the same
  // edge therefore see the same history, and the read observes the old counter.
  assign req_idx = USE_PC ? (bus.req_pc ^ hist_q) : hist_q;
  assign res_idx = USE_PC ? (bus.res_pc ^ hist_q) : hist_q;
  assign req_ctr = ctr_flat[int'(req_idx)*CTR_BITS +: CTR_BITS];

  // Each counter has its own register because reset has to set the whole
  // table to CTR_MAX at once. An inferred RAM cannot be reset to a value.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ctr
    logic [CTR_BITS-1:0] ctr_q, ctr_d;

    always_comb begin
      ctr_d = ctr_q;
      if (bus.result && (res_idx == HIST_BITS'(gi))) begin
        if (bus.taken) begin
          if (ctr_q != CTR_MAX) ctr_d = ctr_q + CTR_ONE;
        end else begin
          if (ctr_q != '0) ctr_d = ctr_q - CTR_ONE;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) ctr_q <= CTR_MAX;
      else     ctr_q <= ctr_d;
    end

    assign ctr_flat[gi*CTR_BITS +: CTR_BITS] = ctr_q;
  end

  // The new outcome shifts in at the LSB and the oldest bit drops off the MSB.
  // Truncating {hist, taken} to HIST_BITS also covers the HIST_BITS=1 case.
  always_comb begin
    hist_d = hist_q;
    if (bus.result) hist_d = HIST_BITS'({hist_q, bus.taken});
  end

  // pred_valid is a single-cycle pulse. prediction and pred_strong hold
  // their values between requests.
  always_comb begin
    prediction_d  = prediction_q;
    pred_strong_d = pred_strong_q;
    pred_valid_d  = 1'b0;
    if (bus.request) begin
      prediction_d  = req_ctr[CTR_BITS-1];
      pred_strong_d = (req_ctr == '0) || (req_ctr == CTR_MAX);
      pred_valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q        <= '0;
      prediction_q  <= 1'b0;
      pred_valid_q  <= 1'b0;
      pred_strong_q <= 1'b0;
    end else begin
      hist_q        <= hist_d;
      prediction_q  <= prediction_d;
      pred_valid_q  <= pred_valid_d;
      pred_strong_q <= pred_strong_d;
    end
  end

  assign bus.prediction  = prediction_q;
  assign bus.pred_valid  = pred_valid_q;
  assign bus.pred_strong = pred_strong_q;
endmodule

// File: tb/tb_history_predictor.sv
// tb_history_predictor
//   This bench drives three predictor configurations with one shared
//   stimulus stream:
//     a : HIST_BITS=4, CTR_BITS=2, gshare
//     b : HIST_BITS=4, CTR_BITS=2, history-only index
//     c : HIST_BITS=2, CTR_BITS=3, gshare (it uses the low 2 PC bits)
//   Directed steps come first, then randomized traffic. The expected outputs
//   come from a plain integer model of each table. The outputs are checked at
//   the falling edge that follows every rising edge.
module tb_history_predictor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  history_predictor_if #(.HIST_BITS(4)) bus_a ();
  history_predictor_if #(.HIST_BITS(4)) bus_b ();
  history_predictor_if #(.HIST_BITS(2)) bus_c ();

  history_predictor #(.HIST_BITS(4), .CTR_BITS(2), .USE_PC(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  history_predictor #(.HIST_BITS(4), .CTR_BITS(2), .USE_PC(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  history_predictor #(.HIST_BITS(2), .CTR_BITS(3), .USE_PC(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  int n_pass = 0;
  int n_total = 0;

  // Reference state: counter values as plain integers and histories as
  // integers in [0, 2^HIST_BITS).
  int ctr_a [16];
  int ctr_b [16];
  int ctr_c [4];
  int hist4, hist2;
  int exp_p  [3];
  int exp_s  [3];
  int exp_v  [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    foreach (ctr_a[i]) ctr_a[i] = 3;
    foreach (ctr_b[i]) ctr_b[i] = 3;
    foreach (ctr_c[i]) ctr_c[i] = 7;
    hist4 = 0;
    hist2 = 0;
    for (int k = 0; k < 3; k++) begin
      exp_p[k] = 0; exp_s[k] = 0; exp_v[k] = 0;
    end
  endtask

  function automatic int sat(input int v, input bit up, input int vmax);
    if (up) return (v < vmax) ? v + 1 : vmax;
    return (v > 0) ? v - 1 : 0;
  endfunction

  task automatic drive_idle();
    bus_a.request = 0; bus_a.req_pc = '0; bus_a.result = 0; bus_a.res_pc = '0; bus_a.taken = 0;
    bus_b.request = 0; bus_b.req_pc = '0; bus_b.result = 0; bus_b.res_pc = '0; bus_b.taken = 0;
    bus_c.request = 0; bus_c.req_pc = '0; bus_c.result = 0; bus_c.res_pc = '0; bus_c.taken = 0;
  endtask

  task automatic check_outputs(input string ctx);
    check({ctx, " a.prediction"},  32'(bus_a.prediction),  32'(exp_p[0]));
    check({ctx, " a.pred_strong"}, 32'(bus_a.pred_strong), 32'(exp_s[0]));
    check({ctx, " a.pred_valid"},  32'(bus_a.pred_valid),  32'(exp_v[0]));
    check({ctx, " b.prediction"},  32'(bus_b.prediction),  32'(exp_p[1]));
    check({ctx, " b.pred_strong"}, 32'(bus_b.pred_strong), 32'(exp_s[1]));
    check({ctx, " b.pred_valid"},  32'(bus_b.pred_valid),  32'(exp_v[1]));
    check({ctx, " c.prediction"},  32'(bus_c.prediction),  32'(exp_p[2]));
    check({ctx, " c.pred_strong"}, 32'(bus_c.pred_strong), 32'(exp_s[2]));
    check({ctx, " c.pred_valid"},  32'(bus_c.pred_valid),  32'(exp_v[2]));
  endtask

  // Each step is one clock cycle. The step drives the inputs just after a
  // falling edge, advances the model, and then checks at the next falling edge.
  task automatic step(input bit rq, input int rpc, input bit rs, input int spc, input bit tk);
    int ia, ib, ic, c;
    bus_a.request = rq; bus_a.req_pc = 4'(rpc); bus_a.result = rs; bus_a.res_pc = 4'(spc); bus_a.taken = tk;
    bus_b.request = rq; bus_b.req_pc = 4'(rpc); bus_b.result = rs; bus_b.res_pc = 4'(spc); bus_b.taken = tk;
    bus_c.request = rq; bus_c.req_pc = 2'(rpc); bus_c.result = rs; bus_c.res_pc = 2'(spc); bus_c.taken = tk;

    // Predictions read the table and history as they were before this edge.
    for (int k = 0; k < 3; k++) exp_v[k] = rq;
    if (rq) begin
      c = ctr_a[(rpc % 16) ^ hist4]; exp_p[0] = (c >= 2); exp_s[0] = (c == 0 || c == 3);
      c = ctr_b[hist4];              exp_p[1] = (c >= 2); exp_s[1] = (c == 0 || c == 3);
      c = ctr_c[(rpc % 4) ^ hist2];  exp_p[2] = (c >= 4); exp_s[2] = (c == 0 || c == 7);
    end
    if (rs) begin
      ia = (spc % 16) ^ hist4;
      ib = hist4;
      ic = (spc % 4) ^ hist2;
      ctr_a[ia] = sat(ctr_a[ia], tk, 3);
      ctr_b[ib] = sat(ctr_b[ib], tk, 3);
      ctr_c[ic] = sat(ctr_c[ic], tk, 7);
      hist4 = (hist4 * 2 + int'(tk)) % 16;
      hist2 = (hist2 * 2 + int'(tk)) % 4;
    end

    @(posedge clk);
    @(negedge clk);
    $display("step req=%0d rpc=%0d res=%0d spc=%0d tk=%0d | a p%0d s%0d v%0d | b p%0d s%0d v%0d | c p%0d s%0d v%0d",
             rq, rpc, rs, spc, tk,
             bus_a.prediction, bus_a.pred_strong, bus_a.pred_valid,
             bus_b.prediction, bus_b.pred_strong, bus_b.pred_valid,
             bus_c.prediction, bus_c.pred_strong, bus_c.pred_valid);
    check_outputs("step");
  endtask

  // Assert reset between clock edges. The outputs must clear with no edge.
  task automatic async_reset();
    drive_idle();
    #2 rst = 1'b1;
    #1;
    model_reset();
    $display("async reset asserted mid-cycle");
    check_outputs("async_rst");
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs("reset");
    rst = 1'b0;

    // Request after reset: strongly taken. Then the valid pulse drops and the
    // prediction holds.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Saturate the counter at index 5 downward. History stays at 0.
    repeat (4) step(0, 0, 1, 5, 0);
    step(1, 5, 0, 0, 0);
    step(1, 4, 0, 0, 0);

    // Gshare aliasing: a taken result moves the history to 0001.
    step(0, 0, 1, 0, 1);
    step(1, 4, 0, 0, 0);

    // Reset mid-stream, then request at index 5.
    async_reset();
    step(1, 5, 0, 0, 0);

    // Simultaneous request and result at the same index with a weak counter.
    async_reset();
    step(0, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);

    // Walk the deeper counters downward to the floor and check each step.
    async_reset();
    repeat (8) step(1, 0, 1, 0, 0);
    repeat (8) step(1, 0, 1, 0, 1);

    // Randomized traffic. It mixes idle cycles, requests only, results only,
    // and both together.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
           1'($urandom_range(0, 2) != 0));
      if (i == 150) async_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
